// File: rtl/pc_sequencer.sv
// Program sequencer: owns the PC, fetches one 16-bit instruction word per
// REQ/ACK handshake, holds it on prg for the jump decoder and forms the next
// PC from the decoder's jump controls once the datapath is ready.
module pc_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter int                OFS_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    fetch_req,
    output logic [ADDR_W-1:0]       fetch_addr,
    input  logic                    fetch_ack,
    input  logic [15:0]             fetch_data,
    output logic [15:0]             prg,
    output logic                    exec_valid,
    input  logic                    stall,
    input  logic                    jump,
    input  logic                    jumpr,
    input  logic                    page,
    input  logic                    page0,
    input  logic [ADDR_W-OFS_W-1:0] page_reg,
    input  logic [OFS_W-1:0]        acc,
    output logic [ADDR_W-1:0]       pc,
    output logic                    taken
);

    localparam int PAGE_W = ADDR_W - OFS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] next_pc;
    logic [15:0]       prg_nxt;
    logic              taken_nxt;
    logic [OFS_W-1:0]  tgt;

    // Jump target offset: only the low seven instruction bits, zero-extended.
    assign tgt = {{(OFS_W-7){1'b0}}, prg[6:0]};

    // Next-PC selection; register-indirect beats every direct jump form,
    // and the sequential case wraps across pages and past the top address.
    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (jumpr)
            next_pc = {pc[ADDR_W-1:OFS_W], acc};
        else if (jump && page)
            next_pc = {page_reg, tgt};
        else if (jump && page0)
            next_pc = {{PAGE_W{1'b0}}, tgt};
        else if (jump)
            next_pc = {pc[ADDR_W-1:OFS_W], tgt};
    end

    // Next-state logic: fetch handshake, execute/stall, PC update.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt = state;
        pc_nxt    = pc;
        prg_nxt   = prg;
        taken_nxt = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (fetch_ack) begin
                    prg_nxt   = fetch_data;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_nxt    = next_pc;
                    taken_nxt = jumpr | jump;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset has priority over any handshake or jump.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            prg   <= '0;
            taken <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            prg   <= prg_nxt;
            taken <= taken_nxt;
        end
    end

    assign fetch_req  = (state == FETCH);
    assign fetch_addr = pc;
    assign exec_valid = (state == EXEC);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a scoreboard queue holds the expected next
// fetch address and TAKEN value, pushed when an EXEC step is driven and
// popped when the sequencer raises its next fetch request.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_data;
    logic [15:0] prg;
    logic        exec_valid;
    logic        stall;
    logic        jump;
    logic        jumpr;
    logic        page;
    logic        page0;
    logic [7:0]  page_reg;
    logic [7:0]  acc;
    logic [15:0] pc;
    logic        taken;

    typedef struct {
        logic [15:0] addr;
        logic        tk;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_wait = 0;

    pc_sequencer #(.ADDR_W(16), .OFS_W(8), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .prg        (prg),
        .exec_valid (exec_valid),
        .stall      (stall),
        .jump       (jump),
        .jumpr      (jumpr),
        .page       (page),
        .page0      (page0),
        .page_reg   (page_reg),
        .acc        (acc),
        .pc         (pc),
        .taken      (taken)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_decoder();
        jump     = 1'b0;
        jumpr    = 1'b0;
        page     = 1'b0;
        page0    = 1'b0;
        page_reg = 8'h00;
        acc      = 8'h00;
    endtask

    // One instruction: wait for the request, optionally delay the ACK,
    // optionally stall in EXEC, then release with the given decoder inputs.
    task automatic run_instr(input string name, input logic [15:0] data,
                             input logic j, input logic jr, input logic pg, input logic pg0,
                             input logic [7:0] preg, input logic [7:0] a,
                             input int ack_dly, input int stall_n,
                             input logic [15:0] exp_pc, input logic exp_tk);
        exp_t e;
        int   n;
        n = 0;
        while (!fetch_req && n < 20) begin
            tick();
            n++;
        end
        check({name, " req_seen"}, 32'(fetch_req), 32'd1);
        check({name, " req_wait"}, 32'(n), 32'(exp_wait));
        exp_wait = 0;
        if (sb.size() == 0) begin
            check({name, " sb_empty"}, 32'(sb.size()), 32'd1);
            e.addr = 16'hxxxx;
            e.tk   = 1'bx;
        end else begin
            e = sb.pop_front();
        end
        check({name, " fetch_addr"}, 32'(fetch_addr), 32'(e.addr));
        check({name, " taken"}, 32'(taken), 32'(e.tk));

        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check({name, " hold_req"}, 32'(fetch_req), 32'd1);
            check({name, " hold_addr"}, 32'(fetch_addr), 32'(e.addr));
            check({name, " hold_taken"}, 32'(taken), 32'd0);
        end

        fetch_ack  = 1'b1;
        fetch_data = data;
        tick();
        fetch_ack  = 1'b0;
        fetch_data = 16'(~data);
        check({name, " exec_valid"}, 32'(exec_valid), 32'd1);
        check({name, " prg"}, 32'(prg), 32'(data));
        check({name, " req_drop"}, 32'(fetch_req), 32'd0);

        stall = 1'b1;
        for (int i = 0; i < stall_n; i++) begin
            jump       = 1'($urandom);
            jumpr      = 1'($urandom);
            page       = 1'($urandom);
            page0      = 1'($urandom);
            page_reg   = 8'($urandom);
            acc        = 8'($urandom);
            fetch_ack  = 1'b1;
            fetch_data = 16'($urandom);
            tick();
            check({name, " stall_valid"}, 32'(exec_valid), 32'd1);
            check({name, " stall_pc"}, 32'(pc), 32'(e.addr));
            check({name, " stall_prg"}, 32'(prg), 32'(data));
            check({name, " stall_taken"}, 32'(taken), 32'd0);
        end
        fetch_ack = 1'b0;
        stall     = 1'b0;

        jump     = j;
        jumpr    = jr;
        page     = pg;
        page0    = pg0;
        page_reg = preg;
        acc      = a;
        e.addr   = exp_pc;
        e.tk     = exp_tk;
        sb.push_back(e);
        tick();
        clear_decoder();
    endtask

    initial begin
        exp_t e;
        rst        = 1'b1;
        fetch_ack  = 1'b0;
        fetch_data = 16'h0000;
        stall      = 1'b0;
        clear_decoder();
        @(negedge clk);
        tick();
        rst = 1'b0;
        check("rst pc", 32'(pc), 32'h0);
        check("rst prg", 32'(prg), 32'h0);
        check("rst req", 32'(fetch_req), 32'd0);
        check("rst valid", 32'(exec_valid), 32'd0);
        check("rst taken", 32'(taken), 32'd0);

        // Sequential fetch from reset with zero-wait memory.
        e.addr = 16'h0000; e.tk = 1'b0; sb.push_back(e);
        exp_wait = 1;
        run_instr("seq0", 16'h0000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h0001, 0);
        run_instr("seq1", 16'h0000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h0002, 0);
        run_instr("seq2", 16'h0000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h0003, 0);
        run_instr("seq3", 16'h0000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h0004, 0);

        // Page carry and full wrap of the sequential increment.
        run_instr("to12",   16'h0000, 1, 0, 1, 0, 8'h12, 8'h00, 0, 0, 16'h1200, 1);
        run_instr("to12ff", 16'h0000, 0, 1, 0, 0, 8'h00, 8'hFF, 0, 0, 16'h12FF, 1);
        run_instr("carry",  16'h0000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h1300, 0);
        run_instr("toff",   16'h0000, 1, 0, 1, 0, 8'hFF, 8'h00, 0, 0, 16'hFF00, 1);
        run_instr("toffff", 16'h0000, 0, 1, 0, 0, 8'h00, 8'hFF, 0, 0, 16'hFFFF, 1);
        run_instr("wrap",   16'h0000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h0000, 0);

        // Direct jumps; bit 7 of the word must not reach the target.
        run_instr("to1234", 16'hFFB4, 1, 0, 1, 0, 8'h12, 8'h00, 0, 0, 16'h1234, 1);
        run_instr("near",   16'h0055, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h1255, 1);
        run_instr("back",   16'h0034, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h1234, 1);
        run_instr("page0",  16'h0055, 1, 0, 0, 1, 8'h77, 8'h00, 0, 0, 16'h0055, 1);
        run_instr("back2",  16'h0034, 1, 0, 1, 0, 8'h12, 8'h00, 0, 0, 16'h1234, 1);
        run_instr("far",    16'h00D5, 1, 0, 1, 1, 8'hA0, 8'h00, 0, 0, 16'hA055, 1);

        // Register-indirect priority, then PAGE without JUMP.
        run_instr("to4000", 16'h0000, 1, 0, 1, 0, 8'h40, 8'h00, 0, 0, 16'h4000, 1);
        run_instr("jumpr",  16'h0055, 1, 1, 1, 0, 8'h77, 8'hC3, 0, 0, 16'h40C3, 1);
        run_instr("pgonly", 16'h0055, 0, 0, 1, 1, 8'h99, 8'h00, 0, 0, 16'h40C4, 0);

        // Withheld ACK and a four-cycle stall with a toggling decoder.
        run_instr("wait",   16'h1357, 0, 0, 0, 0, 8'h00, 8'h00, 3, 4, 16'h40C5, 0);

        // Reset during FETCH, ACK arriving in IDLE must be dropped.
        check("rst6 req", 32'(fetch_req), 32'd1);
        e = sb.pop_front();
        check("rst6 addr", 32'(fetch_addr), 32'(e.addr));
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        fetch_ack  = 1'b1;
        fetch_data = 16'hBEEF;
        check("rst6 req_drop", 32'(fetch_req), 32'd0);
        check("rst6 pc", 32'(pc), 32'h0);
        check("rst6 prg", 32'(prg), 32'h0);
        tick();
        fetch_ack = 1'b0;
        check("rst6 prg_kept", 32'(prg), 32'h0);
        check("rst6 valid", 32'(exec_valid), 32'd0);
        e.addr = 16'h0000; e.tk = 1'b0; sb.push_back(e);
        run_instr("post", 16'h0000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h0001, 0);

        // Drain the last expectation.
        check("end req", 32'(fetch_req), 32'd1);
        e = sb.pop_front();
        check("end addr", 32'(fetch_addr), 32'(e.addr));
        check("end taken", 32'(taken), 32'(e.tk));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
